// File: rtl/decoder_arb_pkg.sv
// Shared constants and the FSM state encoding for the round-robin
// chip-select arbiter.
//   NUM_REQ    : number of requesters (fixed by the 4-to-16 decoder)
//   SEL_W      : select width, clog2(NUM_REQ)
//   HOLD_CNT_W : width of the per-grant hold counter
package decoder_arb_pkg;

  localparam int NUM_REQ    = 16;
  localparam int SEL_W      = 4;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request bit found scanning
// ptr, ptr+1, ... (mod NUM_REQ).
//   req [NUM_REQ-1:0] in  : request vector
//   ptr [SEL_W-1:0]   in  : highest-priority index
//   any               out : at least one request is set
//   idx [SEL_W-1:0]   out : winning index (valid when any=1)
module rr_priority_pick
  import decoder_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so that bit 0 of rot is req[ptr]; the SEL_W-bit add wraps mod 16.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Lowest set bit of the rotated vector: scan from the top so the last
  // assignment wins.
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + off;  // un-rotate, wraps mod 16

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one shared 16-way resource. A registered 4-bit
// select plus enable drive a 4-to-16 decoder producing a one-hot grant.
// A winner keeps the grant while its request stays high, optionally limited
// to HOLD_MAX consecutive cycles (0 = unlimited). One dead cycle (GAP)
// separates consecutive grants.
//   clock          in  : rising-edge clock
//   reset_n        in  : asynchronous active-low reset
//   arb_en         in  : allow new grants (a running grant is unaffected)
//   req [15:0]     in  : level requests
//   grant [15:0]   out : one-hot grant, zero when grant_valid=0
//   grant_sel [3:0]out : current / last winner
//   grant_valid    out : grant active (decoder enable)
//   timeout        out : one-cycle pulse in the GAP after a forced release
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   grant_sel,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);
  localparam logic                  HOLD_EN  = (HOLD_MAX != 0);

  arb_state_e            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  timeout_q, timeout_d;

  logic                  pick_any;
  logic [SEL_W-1:0]      pick_idx;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_GRANT: begin
        // Only the owner's bit matters while granted; arb_en is ignored.
        if (!req[sel_q]) begin
          state_d = ARB_GAP;
          ptr_d   = sel_q + 1'b1;
        end else if (HOLD_EN && hold_q == HOLD_LIM) begin
          // Forced release: the pointer moves past the owner, so it can
          // only win again when nobody else is asking.
          state_d   = ARB_GAP;
          ptr_d     = sel_q + 1'b1;
          timeout_d = 1'b1;
        end else if (HOLD_EN && hold_q < HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        // IDLE and GAP both arbitrate; grant_sel keeps its last value.
        if (arb_en && pick_any) begin
          state_d = ARB_GRANT;
          sel_d   = pick_idx;
          hold_d  = HOLD_CNT_W'(1);
        end else begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid = (state_q == ARB_GRANT);
  assign grant_sel   = sel_q;
  assign timeout     = timeout_q;

  // 4-to-16 decoder with enable.
  always_comb begin
    grant = '0;
    if (grant_valid) grant[sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        arb_en = 1'b1;
  logic [15:0] req_a = '0;   // unlimited-hold instance
  logic [15:0] req_b = '0;   // HOLD_MAX=3 instance

  logic [15:0] grant_u, grant_h;
  logic [3:0]  sel_u, sel_h;
  logic        valid_u, valid_h, to_u, to_h;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  decoder_rr_arbiter #(.HOLD_MAX(0)) dut_u (
    .clock(clock), .reset_n(reset_n), .arb_en(arb_en), .req(req_a),
    .grant(grant_u), .grant_sel(sel_u), .grant_valid(valid_u), .timeout(to_u));

  decoder_rr_arbiter #(.HOLD_MAX(3)) dut_h (
    .clock(clock), .reset_n(reset_n), .arb_en(arb_en), .req(req_b),
    .grant(grant_h), .grant_sel(sel_h), .grant_valid(valid_h), .timeout(to_h));

  // Reference model: who owns the resource, for how long, and where the
  // round-robin scan starts next.
  typedef struct {
    logic v;
    int   sel;
    int   cnt;
    int   ptr;
    logic to;
  } mdl_t;

  localparam mdl_t M0 = '{v: 1'b0, sel: 0, cnt: 0, ptr: 0, to: 1'b0};
  mdl_t mu = M0;
  mdl_t mh = M0;

  function automatic mdl_t mstep(mdl_t m, logic [15:0] r, logic en, int hm);
    mdl_t n = m;
    logic found = 1'b0;
    n.to = 1'b0;
    if (m.v) begin
      if (!r[m.sel]) begin
        n.v = 1'b0; n.ptr = (m.sel + 1) % 16;
      end else if (hm != 0 && m.cnt == hm) begin
        n.v = 1'b0; n.ptr = (m.sel + 1) % 16; n.to = 1'b1;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else if (en && r != 16'h0) begin
      for (int i = 0; i < 16; i++) begin
        if (!found && r[(m.ptr + i) % 16]) begin
          found = 1'b1; n.v = 1'b1; n.sel = (m.ptr + i) % 16; n.cnt = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_grant(mdl_t m);
    logic [15:0] g = '0;
    if (m.v) g[m.sel] = 1'b1;
    return g;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mu <= M0;
      mh <= M0;
    end else begin
      mu <= mstep(mu, req_a, arb_en, 0);
      mh <= mstep(mh, req_b, arb_en, 3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clock) begin
    #2;
    if (reset_n) begin
      chk("u_grant", grant_u, exp_grant(mu));
      chk("u_valid", valid_u, mu.v);
      chk("u_sel", sel_u, mu.sel);
      chk("u_timeout", to_u, mu.to);
      chk("h_grant", grant_h, exp_grant(mh));
      chk("h_valid", valid_h, mh.v);
      chk("h_sel", sel_h, mh.sel);
      chk("h_timeout", to_h, mh.to);
    end
  end

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    // 1: reset, single requester 0
    repeat (2) nxt();
    chk("rst_grant", grant_u, 16'h0);
    chk("rst_valid", valid_u, 1'b0);
    reset_n = 1'b1;
    nxt();
    req_a = 16'h0001;
    nxt();
    chk("t1_grant", grant_u, 16'h0001);
    chk("t1_sel", sel_u, 4'd0);
    req_a = 16'h0000;
    nxt();
    chk("t1_gap", grant_u, 16'h0);
    nxt();
    chk("t1_idle", valid_u, 1'b0);
    chk("t1_mptr", mu.ptr, 1);

    // 2: all requesting, each winner drops after 2 cycles
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
    req_a = 16'hFFFF;
    nxt();
    for (int k = 0; k < 17; k++) begin
      chk("t2_sel", sel_u, k % 16);
      chk("t2_v1", valid_u, 1'b1);
      nxt();
      chk("t2_v2", valid_u, 1'b1);
      req_a = 16'hFFFF & ~(16'h1 << (k % 16));
      nxt();
      chk("t2_gap", grant_u, 16'h0);
      req_a = 16'hFFFF;
      nxt();
    end
    req_a = 16'h0;
    repeat (2) nxt();

    // 3: hold limit 3 on requester 5
    req_b = 16'h0020;
    nxt();
    chk("t3_c1", grant_h, 16'h0020);
    nxt();
    chk("t3_c2", grant_h, 16'h0020);
    nxt();
    chk("t3_c3", grant_h, 16'h0020);
    nxt();
    chk("t3_gap", grant_h, 16'h0);
    chk("t3_to", to_h, 1'b1);
    nxt();
    chk("t3_regrant", grant_h, 16'h0020);
    chk("t3_to_off", to_h, 1'b0);
    chk("t3_mptr", mh.ptr, 6);

    // 4: pointer priority and wrap
    req_b = 16'h0;
    repeat (2) nxt();
    req_b = 16'h0050;
    nxt();
    chk("t4_sel6", sel_h, 4'd6);
    chk("t4_g6", grant_h, 16'h0040);
    req_b = 16'h0010;
    nxt();
    chk("t4_mptr", mh.ptr, 7);
    req_b = 16'h0050;
    nxt();
    chk("t4_sel4", sel_h, 4'd4);
    chk("t4_g4", grant_h, 16'h0010);
    req_b = 16'h0;
    repeat (2) nxt();

    // 5: arb_en gating
    arb_en = 1'b0;
    req_a = 16'h0100;
    repeat (3) nxt();
    chk("t5_blocked", grant_u, 16'h0);
    arb_en = 1'b1;
    nxt();
    chk("t5_g8", grant_u, 16'h0100);
    arb_en = 1'b0;
    repeat (20) nxt();
    chk("t5_held", grant_u, 16'h0100);
    req_a = 16'h0;
    arb_en = 1'b1;
    nxt();
    chk("t5_rel", grant_u, 16'h0);
    nxt();

    // 6: async reset mid-grant
    req_a = 16'h0200;
    nxt();
    chk("t6_g9", grant_u, 16'h0200);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_grant", grant_u, 16'h0);
    chk("t6_async_valid", valid_u, 1'b0);
    chk("t6_async_sel", sel_u, 4'd0);
    chk("t6_async_to", to_u, 1'b0);
    nxt();
    reset_n = 1'b1;
    nxt();
    chk("t6_regrant", grant_u, 16'h0200);
    chk("t6_sel", sel_u, 4'd9);
    req_a = 16'h0;
    repeat (2) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
